// File: rtl/uidma_wr.sv
// uidma_wr: turns one DMA line request into AXI4 INCR write bursts.
// Bursts are capped at AXI_MAX_BURST beats and never cross a 4 KB boundary.
// Beats are pulled from a first-word-fall-through FIFO.
module uidma_wr #(
    parameter int unsigned AXI_DATA_WIDTH = 128,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_MAX_BURST  = 64
) (
    input  logic                          ui_clk,
    input  logic                          ui_rstn,
    input  logic [AXI_ADDR_WIDTH-1:0]     dma_waddr,
    input  logic                          dma_wareq,
    input  logic [15:0]                   dma_wsize,
    output logic                          dma_wbusy,
    input  logic [AXI_DATA_WIDTH-1:0]     dma_wdata,
    output logic                          dma_wvalid,
    input  logic                          dma_wready,
    output logic                          dma_werr,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                    m_axi_awlen,
    output logic [2:0]                    m_axi_awsize,
    output logic [1:0]                    m_axi_awburst,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                          m_axi_wlast,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready
);

    localparam int unsigned BYTES     = AXI_DATA_WIDTH / 8;
    localparam int unsigned SIZE_LOG2 = $clog2(BYTES);
    localparam int unsigned LEN_W     = 9;
    localparam int unsigned REM_W     = 16;

    localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~AXI_ADDR_WIDTH'(BYTES - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AW   = 3'd1;
    localparam logic [2:0] S_W    = 3'd2;
    localparam logic [2:0] S_B    = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]                state, state_nxt;
    logic [AXI_ADDR_WIDTH-1:0] cur_addr, cur_addr_nxt;
    logic [REM_W-1:0]          remaining, remaining_nxt;
    logic [LEN_W-1:0]          beat_cnt, beat_cnt_nxt;
    logic [LEN_W-1:0]          len_q, len_nxt;
    logic                      awvalid_q, awvalid_nxt;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_nxt;
    logic [7:0]                awlen_q, awlen_nxt;
    logic                      werr_q, werr_nxt;
    logic                      busy_q, busy_nxt;
    logic                      bready_q, bready_nxt;
    logic [AXI_ADDR_WIDTH-1:0] req_addr;
    logic                      w_fire;
    logic                      w_last;

    // Beats for the next burst: remaining, max burst and room left in the 4 KB page.
    function automatic logic [LEN_W-1:0] burst_len(input logic [11:0] addr_lo,
                                                   input logic [REM_W-1:0] rem);
        logic [12:0] room;
        logic [16:0] len;
        room = (13'h1000 - {1'b0, addr_lo}) >> SIZE_LOG2;
        len  = {1'b0, rem};
        if (len > 17'(AXI_MAX_BURST)) len = 17'(AXI_MAX_BURST);
        if (len > 17'(room))          len = 17'(room);
        return LEN_W'(len);
    endfunction

    assign req_addr      = dma_waddr & ALIGN_MASK;
    assign m_axi_awsize  = 3'(SIZE_LOG2);
    assign m_axi_awburst = 2'b01;
    assign m_axi_wstrb   = '1;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_bready  = bready_q;
    assign dma_wbusy     = busy_q;
    assign dma_werr      = werr_q;

    // W channel passes the FIFO head straight through; the FIFO pops with each beat.
    assign m_axi_wdata  = dma_wdata;
    assign m_axi_wvalid = (state == S_W) & dma_wready;
    assign w_fire       = m_axi_wvalid & m_axi_wready;
    assign dma_wvalid   = w_fire;
    assign w_last       = (beat_cnt == len_q - LEN_W'(1));
    assign m_axi_wlast  = (state == S_W) & w_last;

    // Next-state and next-register values for the request/burst sequencer.
    always_comb begin
        state_nxt     = state;
        cur_addr_nxt  = cur_addr;
        remaining_nxt = remaining;
        beat_cnt_nxt  = beat_cnt;
        len_nxt       = len_q;
        awvalid_nxt   = awvalid_q;
        awaddr_nxt    = awaddr_q;
        awlen_nxt     = awlen_q;
        werr_nxt      = werr_q;
        case (state)
            S_IDLE: begin
                if (dma_wareq) begin
                    werr_nxt      = 1'b0;
                    cur_addr_nxt  = req_addr;
                    remaining_nxt = dma_wsize;
                    if (dma_wsize == 16'd0) begin
                        state_nxt = S_DONE;
                    end else begin
                        len_nxt     = burst_len(req_addr[11:0], dma_wsize);
                        awaddr_nxt  = req_addr;
                        awlen_nxt   = 8'(len_nxt - LEN_W'(1));
                        awvalid_nxt = 1'b1;
                        state_nxt   = S_AW;
                    end
                end
            end
            S_AW: begin
                if (m_axi_awready) begin
                    awvalid_nxt  = 1'b0;
                    beat_cnt_nxt = '0;
                    state_nxt    = S_W;
                end
            end
            S_W: begin
                if (w_fire) begin
                    if (w_last) begin
                        beat_cnt_nxt  = '0;
                        cur_addr_nxt  = cur_addr + (AXI_ADDR_WIDTH'(len_q) << SIZE_LOG2);
                        remaining_nxt = remaining - REM_W'(len_q);
                        state_nxt     = S_B;
                    end else begin
                        beat_cnt_nxt = beat_cnt + LEN_W'(1);
                    end
                end
            end
            S_B: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp inside {2'b10, 2'b11}) werr_nxt = 1'b1;
                    if (remaining == '0) begin
                        state_nxt = S_DONE;
                    end else begin
                        len_nxt     = burst_len(cur_addr[11:0], remaining);
                        awaddr_nxt  = cur_addr;
                        awlen_nxt   = 8'(len_nxt - LEN_W'(1));
                        awvalid_nxt = 1'b1;
                        state_nxt   = S_AW;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        busy_nxt   = (state_nxt != S_IDLE);
        bready_nxt = (state_nxt == S_B);
    end

    // State and registered outputs; reset clears everything mid-burst.
    always_ff @(posedge ui_clk or negedge ui_rstn) begin
        if (!ui_rstn) begin
            state     <= S_IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            beat_cnt  <= '0;
            len_q     <= '0;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            werr_q    <= 1'b0;
            busy_q    <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur_addr  <= cur_addr_nxt;
            remaining <= remaining_nxt;
            beat_cnt  <= beat_cnt_nxt;
            len_q     <= len_nxt;
            awvalid_q <= awvalid_nxt;
            awaddr_q  <= awaddr_nxt;
            awlen_q   <= awlen_nxt;
            werr_q    <= werr_nxt;
            busy_q    <= busy_nxt;
            bready_q  <= bready_nxt;
        end
    end

endmodule

// File: tb/tb_uidma_wr.sv
// tb_uidma_wr: directed requests against a burst-list model of uidma_wr.
`timescale 1ns/1ps
module tb_uidma_wr;

    localparam int unsigned DW = 128;
    localparam int unsigned AW = 32;

    logic          ui_clk = 1'b0;
    logic          ui_rstn;
    logic [AW-1:0] dma_waddr;
    logic          dma_wareq;
    logic [15:0]   dma_wsize;
    logic          dma_wbusy;
    logic [DW-1:0] dma_wdata;
    logic          dma_wvalid;
    logic          dma_wready = 1'b1;
    logic          dma_werr;
    logic [AW-1:0] m_axi_awaddr;
    logic [7:0]    m_axi_awlen;
    logic [2:0]    m_axi_awsize;
    logic [1:0]    m_axi_awburst;
    logic          m_axi_awvalid;
    logic          m_axi_awready = 1'b1;
    logic [DW-1:0] m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic          m_axi_wlast;
    logic          m_axi_wvalid;
    logic          m_axi_wready = 1'b1;
    logic [1:0]    m_axi_bresp = 2'b00;
    logic          m_axi_bvalid = 1'b0;
    logic          m_axi_bready;

    always #5 ui_clk = ~ui_clk;

    uidma_wr #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .AXI_MAX_BURST(64)) dut (
        .ui_clk(ui_clk), .ui_rstn(ui_rstn),
        .dma_waddr(dma_waddr), .dma_wareq(dma_wareq), .dma_wsize(dma_wsize),
        .dma_wbusy(dma_wbusy), .dma_wdata(dma_wdata), .dma_wvalid(dma_wvalid),
        .dma_wready(dma_wready), .dma_werr(dma_werr),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc = 0;
    int unsigned rd_ptr = 0;
    int unsigned w_idx = 0;
    int unsigned n_pulse = 0;
    int unsigned last_b_edge = 0;
    int unsigned req_base = 0;
    int          b_pending = 0;
    int          b_idx = 0;
    int          err_at = -1;
    int          w_beat = 0;
    bit          rnd_mode = 1'b0;
    bit          w_last_f = 1'b0;
    bit          b_hs_f = 1'b0;
    bit          pop_f = 1'b0;
    bit          aw_wait = 1'b0;
    logic [31:0] aw_prev_addr;
    logic [7:0]  aw_prev_len;

    logic [31:0] exp_aw_addr[$];
    logic [7:0]  exp_aw_len[$];
    int          exp_wlen[$];
    int          wlast_pos[$];

    // FIFO content: word n is a recognisable function of its index.
    function automatic logic [127:0] word(input int unsigned n);
        return {32'hC0DE_0000 ^ n, ~n, n * 32'd3 + 32'd7, n};
    endfunction

    assign dma_wdata = word(rd_ptr);

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected burst list from plain address arithmetic: 16 bytes/beat, 64-beat cap, 4 KB pages.
    task automatic build_model(input logic [31:0] addr, input logic [15:0] size);
        logic [31:0] a;
        int rem, room, len;
        a   = addr & 32'hFFFF_FFF0;
        rem = int'(size);
        while (rem > 0) begin
            room = (4096 - int'(a % 32'd4096)) / 16;
            len  = rem;
            if (len > 64)   len = 64;
            if (len > room) len = room;
            exp_aw_addr.push_back(a);
            exp_aw_len.push_back(8'(len - 1));
            exp_wlen.push_back(len);
            a   = a + 32'(len * 16);
            rem = rem - len;
        end
    endtask

    // Output monitor: checks every handshake against the model, sampled mid-cycle.
    always @(negedge ui_clk) begin
        w_last_f = 1'b0;
        b_hs_f   = 1'b0;
        pop_f    = 1'b0;
        if (!ui_rstn) begin
            exp_aw_addr.delete();
            exp_aw_len.delete();
            exp_wlen.delete();
            w_beat  = 0;
            aw_wait = 1'b0;
        end else begin
            check("fifo_strobe", dma_wvalid, m_axi_wvalid & m_axi_wready);
            if (!dma_wready) check("wvalid_gate", m_axi_wvalid, 1'b0);
            if (m_axi_awvalid && m_axi_wvalid) check("aw_w_overlap", 1'b1, 1'b0);
            if (aw_wait && m_axi_awvalid) begin
                check("awaddr_stable", m_axi_awaddr, aw_prev_addr);
                check("awlen_stable", m_axi_awlen, aw_prev_len);
            end
            aw_wait      = m_axi_awvalid && !m_axi_awready;
            aw_prev_addr = m_axi_awaddr;
            aw_prev_len  = m_axi_awlen;
            if (m_axi_awvalid && m_axi_awready) begin
                if (exp_aw_addr.size() == 0) begin
                    check("aw_unexpected", 1'b1, 1'b0);
                end else begin
                    check("awaddr", m_axi_awaddr, exp_aw_addr.pop_front());
                    check("awlen", m_axi_awlen, exp_aw_len.pop_front());
                    check("awsize", m_axi_awsize, 3'd4);
                    check("awburst", m_axi_awburst, 2'b01);
                end
            end
            if (m_axi_wvalid && m_axi_wready) begin
                check("wdata", m_axi_wdata, word(w_idx));
                check("wstrb", m_axi_wstrb, 16'hFFFF);
                if (exp_wlen.size() == 0) begin
                    check("w_unexpected", 1'b1, 1'b0);
                end else if (w_beat == exp_wlen[0] - 1) begin
                    check("wlast", m_axi_wlast, 1'b1);
                    void'(exp_wlen.pop_front());
                    w_beat = 0;
                end else begin
                    check("wlast", m_axi_wlast, 1'b0);
                    w_beat++;
                end
                if (m_axi_wlast) begin
                    w_last_f = 1'b1;
                    wlast_pos.push_back(int'(w_idx - req_base));
                end
                w_idx++;
            end
            if (dma_wvalid) begin
                pop_f = 1'b1;
                n_pulse++;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                b_hs_f      = 1'b1;
                last_b_edge = cyc + 1;
            end
        end
    end

    // Slave side: FIFO pop, write responses and ready patterns.
    always @(posedge ui_clk) begin
        cyc++;
        if (!ui_rstn) begin
            b_pending = 0;
        end else begin
            if (pop_f)    rd_ptr++;
            if (w_last_f) b_pending++;
            if (b_hs_f) begin
                b_pending--;
                b_idx++;
            end
        end
        #1;
        if (!ui_rstn || b_hs_f) begin
            m_axi_bvalid = 1'b0;
        end else if (!m_axi_bvalid && b_pending > 0) begin
            m_axi_bvalid = 1'b1;
            m_axi_bresp  = (b_idx == err_at) ? 2'b10 : 2'b00;
        end
        if (rnd_mode) begin
            m_axi_wready  = 1'($urandom_range(0, 1));
            m_axi_awready = 1'($urandom_range(0, 1));
            dma_wready    = ($urandom_range(0, 3) != 0);
        end else begin
            m_axi_wready  = 1'b1;
            m_axi_awready = 1'b1;
            dma_wready    = 1'b1;
        end
    end

    // One request from IDLE to IDLE, with bounded wait and end-of-line checks.
    task automatic run_req(input logic [31:0] addr, input logic [15:0] size, input int err_k,
                           input bit rnd, input bit hold);
        int n;
        int unsigned acc, fall, p0;
        req_base = w_idx;
        p0       = n_pulse;
        wlast_pos.delete();
        rnd_mode = rnd;
        err_at   = (err_k < 0) ? -1 : b_idx + err_k;
        @(posedge ui_clk); #1;
        dma_waddr = addr;
        dma_wsize = size;
        dma_wareq = 1'b1;
        @(posedge ui_clk); #1;
        acc = cyc;
        check("busy_rise", dma_wbusy, 1'b1);
        check("awvalid_rise", m_axi_awvalid, size != 16'd0);
        check("werr_clear", dma_werr, 1'b0);
        if (!hold) dma_wareq = 1'b0;
        n = 0;
        while (dma_wbusy === 1'b1 && n < 4000) begin
            @(posedge ui_clk); #1;
            n++;
        end
        dma_wareq = 1'b0;
        fall = cyc;
        rnd_mode = 1'b0;
        check("busy_timeout", dma_wbusy, 1'b0);
        // Exactly one DONE cycle separates the final event from IDLE.
        if (size == 16'd0) check("done_len_size0", fall - acc, 1);
        else               check("done_len", fall - last_b_edge, 1);
        check("bursts_left", exp_aw_addr.size(), 0);
        check("wbeats_left", exp_wlen.size(), 0);
        check("fifo_pulses", n_pulse - p0, size);
        check("w_beats", w_idx - req_base, size);
        check("werr_end", dma_werr, err_k >= 0);
    endtask

    initial begin
        int n;
        ui_rstn   = 1'b0;
        dma_waddr = '0;
        dma_wsize = '0;
        dma_wareq = 1'b0;
        repeat (2) @(posedge ui_clk);
        #1;
        check("rst_busy", dma_wbusy, 1'b0);
        check("rst_fifo_strobe", dma_wvalid, 1'b0);
        check("rst_werr", dma_werr, 1'b0);
        check("rst_awvalid", m_axi_awvalid, 1'b0);
        check("rst_wvalid", m_axi_wvalid, 1'b0);
        check("rst_wlast", m_axi_wlast, 1'b0);
        check("rst_bready", m_axi_bready, 1'b0);
        check("rst_awaddr", m_axi_awaddr, 32'h0);
        check("rst_awlen", m_axi_awlen, 8'h0);
        check("awsize_const", m_axi_awsize, 3'd4);
        check("awburst_const", m_axi_awburst, 2'b01);
        check("wstrb_const", m_axi_wstrb, 16'hFFFF);
        @(posedge ui_clk); #3;
        ui_rstn = 1'b1;

        // 240 beats from a 1 KB-aligned address, request held through DONE.
        build_model(32'h1000_0000, 16'd240);
        check("model1_count", exp_aw_addr.size(), 4);
        check("model1_addr1", exp_aw_addr[1], 32'h1000_0400);
        check("model1_addr3", exp_aw_addr[3], 32'h1000_0C00);
        check("model1_len0", exp_aw_len[0], 8'd63);
        check("model1_len3", exp_aw_len[3], 8'd47);
        run_req(32'h1000_0000, 16'd240, -1, 1'b0, 1'b1);
        repeat (3) begin
            @(posedge ui_clk); #1;
            check("idle_after_hold", {dma_wbusy, m_axi_awvalid}, 2'b00);
        end

        // 4 KB split: 16 beats up to the page end, then 24.
        build_model(32'h0000_0F00, 16'd40);
        check("model2_addr0", exp_aw_addr[0], 32'h0000_0F00);
        check("model2_len0", exp_aw_len[0], 8'd15);
        check("model2_addr1", exp_aw_addr[1], 32'h0000_1000);
        check("model2_len1", exp_aw_len[1], 8'd23);
        run_req(32'h0000_0F00, 16'd40, -1, 1'b0, 1'b0);

        // Random back-pressure on AW, W and the FIFO.
        build_model(32'h2000_0000, 16'd100);
        run_req(32'h2000_0000, 16'd100, -1, 1'b1, 1'b0);
        check("wlast_count", wlast_pos.size(), 2);
        if (wlast_pos.size() == 2) begin
            check("wlast_pos0", wlast_pos[0], 63);
            check("wlast_pos1", wlast_pos[1], 99);
        end

        // SLVERR on the second of three bursts; error stays sticky.
        build_model(32'h3000_0000, 16'd150);
        check("model4_len2", exp_aw_len[2], 8'd21);
        run_req(32'h3000_0000, 16'd150, 1, 1'b0, 1'b0);
        repeat (3) @(posedge ui_clk);
        #1;
        check("werr_sticky", dma_werr, 1'b1);

        // Zero-length line: one busy cycle, no AXI traffic, error cleared.
        build_model(32'h3000_0000, 16'd0);
        run_req(32'h3000_0000, 16'd0, -1, 1'b0, 1'b0);

        // Reset while beat 10 is on the W channel.
        build_model(32'h4000_0000, 16'd40);
        req_base = w_idx;
        @(posedge ui_clk); #1;
        dma_waddr = 32'h4000_0000;
        dma_wsize = 16'd40;
        dma_wareq = 1'b1;
        @(posedge ui_clk); #1;
        dma_wareq = 1'b0;
        n = 0;
        while ((w_idx - req_base) < 10 && n < 500) begin
            @(posedge ui_clk); #2;
            n++;
        end
        check("reach_beat10", w_idx - req_base, 10);
        check("beat10_presented", m_axi_wvalid, 1'b1);
        ui_rstn = 1'b0;
        #1;
        check("arst_busy", dma_wbusy, 1'b0);
        check("arst_fifo_strobe", dma_wvalid, 1'b0);
        check("arst_werr", dma_werr, 1'b0);
        check("arst_awvalid", m_axi_awvalid, 1'b0);
        check("arst_wvalid", m_axi_wvalid, 1'b0);
        check("arst_wlast", m_axi_wlast, 1'b0);
        check("arst_bready", m_axi_bready, 1'b0);
        check("arst_awaddr", m_axi_awaddr, 32'h0);
        check("arst_awlen", m_axi_awlen, 8'h0);
        repeat (2) @(posedge ui_clk);
        #3;
        ui_rstn = 1'b1;

        // Clean request after reset; unaligned address low bits are dropped.
        build_model(32'h4000_0107, 16'd20);
        check("model6_addr0", exp_aw_addr[0], 32'h4000_0100);
        check("model6_len0", exp_aw_len[0], 8'd19);
        run_req(32'h4000_0107, 16'd20, -1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
